// File: rtl/nave_pkg.sv
// Shared definitions for the ship position controller.
// Visible-area dimensions, coordinate width and the 2-bit state encoding
// of the speed-ramp FSM.
package nave_pkg;

    localparam int H_VISIVEL = 640;
    localparam int V_VISIVEL = 480;
    localparam int COORD_W   = 10;

    typedef enum logic [1:0] {
        PARADO     = 2'd0,
        ACELERANDO = 2'd1,
        CRUZEIRO   = 2'd2
    } estado_t;

endpackage

// File: rtl/sincronizador.sv
// Two-stage synchronizer for a bus of independent asynchronous inputs.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high; both stages load RST_VAL
//   d     - asynchronous inputs
//   q     - synchronized outputs (two clock edges of latency)
module sincronizador #(
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nave_controle.sv
// Ship position controller. Samples the push-buttons once per video frame
// (on the VGA_VS falling edge) and moves the ship with a speed ramp:
// speed grows by one pixel/frame while any direction is held, up to
// VEL_MAX, and drops to zero on release. Position saturates so the whole
// ship rectangle stays inside the visible area.
// Ports:
//   CLOCK_50    - system clock
//   reset       - asynchronous, active-high
//   VGA_VS      - vertical sync, active-low
//   btn_esq/dir/cima/baixo - buttons, active-low, asynchronous
//   xNave/yNave - ship top-left corner, visible-area origin
//   larguraNave/alturaNave - constant ship size
//   frame_tick  - one-cycle pulse per VGA_VS falling edge
//   estado/vel  - FSM state and current speed, exposed for observation
module nave_controle
    import nave_pkg::*;
#(
    parameter int LARGURA = 32,
    parameter int ALTURA  = 16,
    parameter int VEL_MAX = 4,
    parameter int X_INI   = 304,
    parameter int Y_INI   = 440
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               VGA_VS,
    input  logic               btn_esq,
    input  logic               btn_dir,
    input  logic               btn_cima,
    input  logic               btn_baixo,
    output logic [COORD_W-1:0] xNave,
    output logic [COORD_W-1:0] yNave,
    output logic [COORD_W-1:0] larguraNave,
    output logic [COORD_W-1:0] alturaNave,
    output logic               frame_tick,
    output estado_t            estado,
    output logic [COORD_W-1:0] vel
);

    // The renderer draws inclusive spans, hence the extra -1.
    localparam logic [10:0] XMAX = 11'(H_VISIVEL - 1 - LARGURA);
    localparam logic [10:0] YMAX = 11'(V_VISIVEL - 1 - ALTURA);
    localparam logic [10:0] VMAX = 11'(VEL_MAX);

    assign larguraNave = COORD_W'(LARGURA);
    assign alturaNave  = COORD_W'(ALTURA);

    // All five inputs idle high, so the synchronizer resets to ones and
    // no spurious edge or press appears when reset is released.
    logic [4:0] sync_out;

    sincronizador #(
        .W       (5),
        .RST_VAL (5'b11111)
    ) u_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .d     ({VGA_VS, btn_esq, btn_dir, btn_cima, btn_baixo}),
        .q     (sync_out)
    );

    logic vs_sync, esq, dir, cima, baixo;
    assign vs_sync = sync_out[4];
    assign esq     = ~sync_out[3];
    assign dir     = ~sync_out[2];
    assign cima    = ~sync_out[1];
    assign baixo   = ~sync_out[0];

    logic vs_prev;

    // Next-move datapath, all in 11 bits so additions cannot wrap.
    logic                mover;
    logic [10:0]         vel_n;
    logic [10:0]         x_sum, y_sum;
    logic [COORD_W-1:0]  x_n, y_n;
    estado_t             estado_n;

    always_comb begin
        mover = (esq ^ dir) | (cima ^ baixo);
        vel_n = ({1'b0, vel} >= VMAX) ? VMAX : {1'b0, vel} + 11'd1;
        x_sum = {1'b0, xNave} + vel_n;
        y_sum = {1'b0, yNave} + vel_n;

        x_n = xNave;
        if (dir && !esq)
            x_n = (x_sum > XMAX) ? XMAX[COORD_W-1:0] : x_sum[COORD_W-1:0];
        else if (esq && !dir)
            x_n = ({1'b0, xNave} < vel_n) ? '0 : COORD_W'({1'b0, xNave} - vel_n);

        y_n = yNave;
        if (baixo && !cima)
            y_n = (y_sum > YMAX) ? YMAX[COORD_W-1:0] : y_sum[COORD_W-1:0];
        else if (cima && !baixo)
            y_n = ({1'b0, yNave} < vel_n) ? '0 : COORD_W'({1'b0, yNave} - vel_n);

        estado_n = (vel_n == VMAX) ? CRUZEIRO : ACELERANDO;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            vs_prev    <= 1'b1;
            frame_tick <= 1'b0;
            xNave      <= COORD_W'(X_INI);
            yNave      <= COORD_W'(Y_INI);
            vel        <= '0;
            estado     <= PARADO;
        end else begin
            vs_prev    <= vs_sync;
            frame_tick <= vs_prev & ~vs_sync;
            // Position only changes here, at the start of vsync.
            if (frame_tick) begin
                if (mover) begin
                    xNave  <= x_n;
                    yNave  <= y_n;
                    vel    <= COORD_W'(vel_n);
                    estado <= estado_n;
                end else begin
                    vel    <= '0;
                    estado <= PARADO;
                end
            end
        end
    end

endmodule

// File: tb/tb_nave_controle.sv
// Bench for nave_controle: directed steps followed by random button
// frames, all checked against a per-frame reference model of the ship.
`timescale 1ns/1ps
module tb_nave_controle;
    import nave_pkg::*;

    localparam int XLIM = 607;   // 639 - 32
    localparam int YLIM = 463;   // 479 - 16
    localparam int VLIM = 4;

    logic               CLOCK_50 = 1'b0;
    logic               reset    = 1'b1;
    logic               VGA_VS   = 1'b1;
    logic               btn_esq  = 1'b1;
    logic               btn_dir  = 1'b1;
    logic               btn_cima = 1'b1;
    logic               btn_baixo = 1'b1;
    logic [COORD_W-1:0] xNave, yNave, larguraNave, alturaNave, vel;
    logic               frame_tick;
    estado_t            estado;

    nave_controle dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .VGA_VS      (VGA_VS),
        .btn_esq     (btn_esq),
        .btn_dir     (btn_dir),
        .btn_cima    (btn_cima),
        .btn_baixo   (btn_baixo),
        .xNave       (xNave),
        .yNave       (yNave),
        .larguraNave (larguraNave),
        .alturaNave  (alturaNave),
        .frame_tick  (frame_tick),
        .estado      (estado),
        .vel         (vel)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_cmp  = 0;
    int n_fail = 0;
    int tick_cnt = 0;

    always @(posedge CLOCK_50) begin
        #1;
        if (frame_tick === 1'b1) tick_cnt++;
    end

    // Reference model: ship position and speed per frame.
    int m_x = 304;
    int m_y = 440;
    int m_vel = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic estado_t exp_estado();
        if (m_vel == 0) return PARADO;
        if (m_vel == VLIM) return CRUZEIRO;
        return ACELERANDO;
    endfunction

    task automatic model_step();
        int dx, dy;
        dx = int'(!btn_dir) - int'(!btn_esq);
        dy = int'(!btn_baixo) - int'(!btn_cima);
        if (dx != 0 || dy != 0) begin
            m_vel = (m_vel + 1 > VLIM) ? VLIM : m_vel + 1;
            m_x = clamp(m_x + dx * m_vel, XLIM);
            m_y = clamp(m_y + dy * m_vel, YLIM);
        end else begin
            m_vel = 0;
        end
    endtask

    task automatic model_reset();
        m_x = 304;
        m_y = 440;
        m_vel = 0;
    endtask

    task automatic set_btns(input logic esq, input logic dir, input logic cima, input logic baixo);
        btn_esq = esq; btn_dir = dir; btn_cima = cima; btn_baixo = baixo;
    endtask

    // One video frame: VS falls, tick must appear at edge k+2 and the
    // position update at edge k+3; VS then stays low for low_len cycles.
    task automatic frame(input int low_len);
        int t0;
        @(negedge CLOCK_50);
        VGA_VS = 1'b0;
        t0 = tick_cnt;
        @(negedge CLOCK_50);
        chk("tick_k", 32'(frame_tick), 0);
        @(negedge CLOCK_50);
        chk("tick_k1", 32'(frame_tick), 0);
        @(negedge CLOCK_50);
        chk("tick_k2", 32'(frame_tick), 1);
        chk("x_before_update", 32'(xNave), 32'(m_x));
        chk("y_before_update", 32'(yNave), 32'(m_y));
        model_step();
        @(negedge CLOCK_50);
        chk("tick_k3", 32'(frame_tick), 0);
        chk("x", 32'(xNave), 32'(m_x));
        chk("y", 32'(yNave), 32'(m_y));
        chk("vel", 32'(vel), 32'(m_vel));
        chk("estado", 32'(estado), 32'(exp_estado()));
        repeat (low_len) @(negedge CLOCK_50);
        VGA_VS = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        chk("ticks_per_frame", 32'(tick_cnt - t0), 1);
    endtask

    initial begin
        int accel_x [6];
        accel_x = '{305, 307, 310, 314, 318, 322};

        // Reset held while VS toggles.
        repeat (8) begin
            @(negedge CLOCK_50);
            VGA_VS = ~VGA_VS;
        end
        chk("rst_x", 32'(xNave), 304);
        chk("rst_y", 32'(yNave), 440);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_tick_cnt", 32'(tick_cnt), 0);
        chk("larg", 32'(larguraNave), 32);
        chk("alt", 32'(alturaNave), 16);
        @(negedge CLOCK_50);
        VGA_VS = 1'b1;
        reset = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        chk("post_rst_tick_cnt", 32'(tick_cnt), 0);

        // Idle frames: no movement.
        repeat (3) frame(4);
        chk("idle_estado", 32'(estado), 32'(PARADO));

        // Acceleration to the right.
        set_btns(1, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            frame(3);
            chk("accel_x_const", 32'(xNave), 32'(accel_x[i]));
            chk("accel_estado_const", 32'(estado),
                (i < 3) ? 32'(ACELERANDO) : 32'(CRUZEIRO));
        end

        // Keep holding right into the wall.
        for (int i = 0; i < 200 && m_x != XLIM; i++) frame(2);
        chk("xmax_reached", 32'(xNave), 32'(XLIM));
        repeat (2) frame(2);
        chk("xmax_stays", 32'(xNave), 32'(XLIM));
        chk("xmax_cruise", 32'(estado), 32'(CRUZEIRO));

        // Release, then press the other way: a single-pixel move.
        set_btns(1, 1, 1, 1);
        frame(2);
        chk("release_vel", 32'(vel), 0);
        set_btns(0, 1, 1, 1);
        frame(2);
        chk("repress_x", 32'(xNave), 32'(XLIM - 1));

        // Opposing horizontal buttons cancel.
        set_btns(0, 0, 1, 1);
        frame(2);
        chk("oppose_vel", 32'(vel), 0);
        chk("oppose_x", 32'(xNave), 32'(XLIM - 1));
        set_btns(0, 0, 0, 1);
        frame(2);
        chk("up_y1", 32'(yNave), 439);
        frame(2);
        chk("up_y2", 32'(yNave), 437);
        chk("up_x_same", 32'(xNave), 32'(XLIM - 1));
        for (int i = 0; i < 200 && m_y != 0; i++) frame(1);
        frame(1);
        chk("ymin_stays", 32'(yNave), 0);

        // Short button pulse that ends before the tick.
        set_btns(1, 1, 1, 1);
        frame(2);
        @(negedge CLOCK_50);
        btn_dir = 1'b0;
        repeat (100) @(negedge CLOCK_50);
        btn_dir = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        frame(2);
        chk("glitch_vel", 32'(vel), 0);

        // Long VS low: still a single tick (checked inside frame).
        frame(2000);

        // Random button frames.
        for (int i = 0; i < 60; i++) begin
            set_btns(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            frame(int'($urandom_range(0, 20)));
        end

        // Reset in the middle of a cruise.
        set_btns(1, 1, 1, 0);
        repeat (5) frame(2);
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        chk("midrst_x", 32'(xNave), 304);
        chk("midrst_y", 32'(yNave), 440);
        chk("midrst_vel", 32'(vel), 0);
        chk("midrst_estado", 32'(estado), 32'(PARADO));
        @(negedge CLOCK_50);
        set_btns(1, 1, 1, 1);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge CLOCK_50);
        frame(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
